// File: rtl/c16_mem_arbiter.sv
// c16_mem_arbiter: shares one synchronous memory port between the CPU and video scanout,
// and routes CPU accesses with addr[15]=1 onto a one-cycle MMIO strobe interface.
module c16_mem_arbiter #(
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    output logic [14:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mmio_re,
    output logic        mmio_we,
    output logic [14:0] mmio_addr,
    output logic [15:0] mmio_wdata,
    input  logic [15:0] mmio_rdata
);
    typedef enum logic [2:0] {IDLE, ISSUE, READ, MMIO, DONE} state_t;
    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  cpu_wait_q, cpu_wait_d;
    logic        win_cpu_q, win_cpu_d;
    logic        we_q, we_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [14:0] mmio_addr_q, mmio_addr_d;
    logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic        mmio_re_q, mmio_re_d, mmio_we_q, mmio_we_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] mmio_wdata_q, mmio_wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] vid_rdata_q, vid_rdata_d;
    logic        cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
    logic        cpu_win;

    // Video has priority unless the CPU has already lost MAX_WAIT grants in a row
    assign cpu_win = cpu_req && (!vid_req || cpu_wait_q == MAX_WAIT);

    always_comb begin
        state_d      = state_q;
        cpu_wait_d   = cpu_wait_q;
        win_cpu_d    = win_cpu_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mmio_addr_d  = mmio_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mmio_wdata_d = mmio_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        vid_rdata_d  = vid_rdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mmio_re_d    = 1'b0;
        mmio_we_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        vid_ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || vid_req) begin
                    win_cpu_d  = cpu_win;
                    we_d       = cpu_win && cpu_we;
                    cpu_wait_d = cpu_win ? 4'd0
                               : (cpu_req && cpu_wait_q < MAX_WAIT) ? cpu_wait_q + 4'd1
                               : cpu_wait_q;
                    if (cpu_win && cpu_addr[15]) begin
                        mmio_addr_d  = cpu_addr[14:0];
                        mmio_wdata_d = cpu_wdata;
                        mmio_re_d    = !cpu_we;
                        mmio_we_d    = cpu_we;
                        state_d      = MMIO;
                    end else begin
                        mem_addr_d  = cpu_win ? cpu_addr[14:0] : vid_addr;
                        mem_re_d    = !(cpu_win && cpu_we);
                        mem_we_d    = cpu_win && cpu_we;
                        mem_wdata_d = (cpu_win && cpu_we) ? cpu_wdata : mem_wdata_q;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: state_d = READ;
            READ: begin
                cpu_rdata_d = win_cpu_q ? (we_q ? 16'h0000 : mem_rdata) : cpu_rdata_q;
                vid_rdata_d = win_cpu_q ? vid_rdata_q : mem_rdata;
                cpu_ack_d   = win_cpu_q;
                vid_ack_d   = !win_cpu_q;
                state_d     = DONE;
            end
            MMIO: begin
                cpu_rdata_d = we_q ? 16'h0000 : mmio_rdata;
                cpu_ack_d   = 1'b1;
                state_d     = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= IDLE;
            cpu_wait_q   <= '0;
            win_cpu_q    <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mmio_addr_q  <= '0;
            mem_wdata_q  <= '0;
            mmio_wdata_q <= '0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mmio_re_q    <= 1'b0;
            mmio_we_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vid_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_wait_q   <= cpu_wait_d;
            win_cpu_q    <= win_cpu_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mmio_addr_q  <= mmio_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mmio_wdata_q <= mmio_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rdata_q  <= vid_rdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mmio_re_q    <= mmio_re_d;
            mmio_we_q    <= mmio_we_d;
            cpu_ack_q    <= cpu_ack_d;
            vid_ack_q    <= vid_ack_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_ack    = vid_ack_q;
    assign vid_rdata  = vid_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign mmio_re    = mmio_re_q;
    assign mmio_we    = mmio_we_q;
    assign mmio_addr  = mmio_addr_q;
    assign mmio_wdata = mmio_wdata_q;
endmodule

// File: doc/c16_mem_arbiter.md
Name: c16_mem_arbiter

Overview:
- Shares the single synchronous 32K-word memory port between the c16 CPU load/store path and a video scanout reader.
- Also decodes CPU MMIO accesses (addr[15]=1) onto a separate one-cycle MMIO strobe interface.
- Video has fixed priority, with a starvation limit that guarantees the CPU progress.
- All transactions use a req/ack handshake; all outputs are registered.

Parameters:
- CPU_MAX_WAIT, 4: consecutive video grants the CPU may lose while requesting before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous reset, active-high despite the name (resetn=1 resets)
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req=1
- cpu_addr  in  16  word address; bit15=1 selects MMIO
- cpu_wdata  in  16  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid when cpu_ack=1
- vid_req  in  1  video read request; held until vid_ack
- vid_addr  in  15  word address
- vid_ack  out  1  one-cycle completion pulse
- vid_rdata  out  16  read data, valid when vid_ack=1
- mem_addr  out  15  memory address
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory data; valid in the cycle after the cycle in which mem_re=1
- mmio_re  out  1  MMIO read strobe
- mmio_we  out  1  MMIO write strobe
- mmio_addr  out  15  cpu_addr[14:0]
- mmio_wdata  out  16  MMIO write data
- mmio_rdata  in  16  combinational MMIO read data, valid while mmio_re=1

Behaviour:
- Reset: every output is 0; state=IDLE; cpu_wait=0. Reset mid-transaction drops the transaction with no ack. Requesters must re-request.
- States: IDLE, ISSUE, READ, MMIO, DONE.
- IDLE, arbitration:
  - CPU wins if cpu_req=1 and either vid_req=0 or cpu_wait==CPU_MAX_WAIT.
  - Otherwise video wins if vid_req=1.
  - With no request, stay in IDLE.
- IDLE, winner actions:
  - Latch winner id, address, we and wdata.
  - CPU with addr[15]=1: register mmio_re or mmio_we for the next cycle, then go to MMIO.
  - Otherwise: register mem_addr, and mem_re (read) or mem_we+mem_wdata (write), then go to ISSUE.
- ISSUE: memory strobe is high for exactly this cycle; clear the strobe; go to READ.
- READ: capture mem_rdata into the winner's rdata register (a write captures nothing and its rdata reads 0); go to DONE.
- MMIO: mmio strobe is high for exactly this cycle; capture mmio_rdata for a read (0 for a write); go to DONE.
- DONE: the winner's ack=1 for exactly this cycle with rdata valid; go to IDLE. rdata holds until the next ack to the same requester.
- Latency from req sampled in IDLE (cycle 0) to ack: memory path ack in cycle 3; MMIO path ack in cycle 2.
- Throughput: one memory transaction per 4 cycles; one MMIO transaction per 3 cycles.
- Requester rule: deassert req on the edge after ack. A req sampled high in IDLE is always treated as a new request.
- cpu_wait counter:
  - Increments, saturating at CPU_MAX_WAIT, on each video grant made while cpu_req=1.
  - Clears to 0 on each CPU grant.
  - Unchanged otherwise.
- Simultaneous requests: video wins unless the starvation limit has been reached. A request arriving during a busy transaction waits in IDLE arbitration.
- Never assert more than one of mem_re, mem_we, mmio_re, mmio_we at once. Never assert both acks in the same cycle.
- Video never reaches MMIO; its addresses are 15 bits.
- mem_addr and mmio_addr hold their last values after the strobe; they are don't-care outside strobe cycles.

Test Plan:
- CPU read, cpu_addr=0x0123, memory word 0x0123 holds 0xBEEF → mem_re=1 in cycle 1 with mem_addr=0x0123; cpu_ack=1 in cycle 3 with cpu_rdata=0xBEEF.
- CPU write, addr=0x0040, data=0x1234, then read of 0x0040 → mem_we pulse with mem_wdata=0x1234; the read returns 0x1234.
- CPU MMIO write, addr=0x8005, data=0x00FF → mmio_we=1 in cycle 1 with mmio_addr=0x0005 and mmio_wdata=0x00FF; mem_we stays 0; cpu_ack in cycle 2.
- cpu_req and vid_req held continuously, CPU_MAX_WAIT=4 → grant order V,V,V,V,C,V,V,V,V,C; acks never overlap.
- Video read vid_addr=0x7FFF, with a CPU read arriving 1 cycle later → video is acked in cycle 3; the CPU is granted in the following IDLE and acked 4 cycles after vid_ack.
- resetn asserted during ISSUE of a CPU read → all outputs 0 the next cycle; no cpu_ack; after release, a held cpu_req is regranted and completes normally.
